// File: rtl/output_deskewer.sv
// output_deskewer
//   Sits directly downstream of the systolic array. It removes the diagonal
//   skew from the array's column outputs, collects MATRIX_SIZE aligned rows
//   in a row buffer, and then drains them one row per handshake toward the
//   writeback stage.
//
// Handshake: a row transfers on every rising edge where out_valid and
//   out_ready are both high. While out_valid is high and out_ready is low,
//   out_data and out_last hold stable. out_valid never drops without a
//   transfer, except on reset.
//
// Optional feature: define OUTPUT_DESKEWER_OVF_CNT_EN to add ovf_count, a
//   16-bit saturating count of dropped rows.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   enable_in     advances the deskew delay lines (they hold when low)
//   data_in       skewed column outputs; column j lags column 0 by j cycles
//   valid_in      qualifies data_in[0] of a row
//   out_data      aligned result row
//   out_valid     out_data is valid
//   out_ready     downstream accepts out_data this cycle
//   out_last      out_data is the final row of the matrix
//   stall_out     high while draining; upstream must hold the array
//   ovf           sticky flag: an aligned row arrived while the buffer was full
//   ovf_clear     synchronous clear of ovf
//   ovf_count     (optional) saturating count of dropped rows
//   dbg_state_o   FSM state (0 = COLLECT, 1 = DRAIN)
module output_deskewer #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable_in,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_in,
  input  logic                                  valid_in,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic                                  stall_out,
  output logic                                  ovf,
  input  logic                                  ovf_clear,
`ifdef OUTPUT_DESKEWER_OVF_CNT_EN
  output logic [15:0]                           ovf_count,
`endif
  output logic                                  dbg_state_o
);

  localparam int PTR_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MATRIX_SIZE - 1);

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  // ---------------------------------------------------------------------
  // Deskew: column j waits MATRIX_SIZE-1-j enabled cycles, so every column
  // of a row lines up with the last column, which passes straight through.
  // ---------------------------------------------------------------------
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned;
  logic                                  row_valid;

  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int DEPTH = MATRIX_SIZE - 1 - j;
    if (DEPTH == 0) begin : g_pass
      assign aligned[j] = data_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] sr_q [DEPTH];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
        end else if (enable_in) begin
          sr_q[0] <= data_in[j];
          for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign aligned[j] = sr_q[DEPTH-1];
    end
  end

  if (MATRIX_SIZE == 1) begin : g_vld_pass
    assign row_valid = valid_in;
  end else begin : g_vld_dly
    logic [MATRIX_SIZE-2:0] vld_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
      end else if (enable_in) begin
        vld_q[0] <= valid_in;
        for (int k = 1; k < MATRIX_SIZE - 1; k++) vld_q[k] <= vld_q[k-1];
      end
    end
    assign row_valid = vld_q[MATRIX_SIZE-2];
  end

  // ---------------------------------------------------------------------
  // Row buffer and COLLECT/DRAIN control
  // ---------------------------------------------------------------------
  state_t                                state_q, state_d;
  logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
  logic                                  ovf_q, ovf_d;
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] buf_q [MATRIX_SIZE];
  logic                                  wr_en;
  logic                                  ovf_set;
  logic                                  row_in;
  logic                                  is_last;

  assign row_in = row_valid & enable_in;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_en     = 1'b0;
    ovf_set   = 1'b0;
    is_last   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    stall_out = 1'b0;
    out_data  = '0;

    case (state_q)
      COLLECT: begin
        if (row_in) wr_en = 1'b1;
      end
      DRAIN: begin
        is_last   = (rd_ptr_q == LAST_IDX);
        out_valid = 1'b1;
        stall_out = 1'b1;
        out_last  = is_last;
        out_data  = buf_q[rd_ptr_q];
        if (out_ready) begin
          if (is_last) begin
            rd_ptr_d = '0;
            state_d  = COLLECT;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
        // The buffer frees up on the final handshake, so a row arriving in
        // that same cycle becomes row 0 of the next matrix (wr_ptr is 0 here).
        if (row_in) begin
          if (out_ready && is_last) wr_en = 1'b1;
          else                      ovf_set = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (wr_en) begin
      if (wr_ptr_q == LAST_IDX) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        state_d  = DRAIN;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    // Set beats clear when both occur together.
    if (ovf_set)        ovf_d = 1'b1;
    else if (ovf_clear) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int r = 0; r < MATRIX_SIZE; r++) buf_q[r] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      if (wr_en) buf_q[wr_ptr_q] <= aligned;
    end
  end

  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

`ifdef OUTPUT_DESKEWER_OVF_CNT_EN
  logic [15:0] ovf_count_q, ovf_count_d;

  // An increment beats a simultaneous clear; the count saturates.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_set) begin
      if (ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
    end else if (ovf_clear) begin
      ovf_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_count_q <= '0;
    else       ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule
